// File: rtl/uart_rx_pkg.sv
// Shared constants and FSM state encoding for the 8N1 UART receiver.
package uart_rx_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;
  localparam int unsigned FRAME_BITS           = 8;
  localparam int unsigned FIFO_DEPTH           = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// 4-entry receive FIFO; head is presented combinationally on dout.
module uart_rx_fifo
  import uart_rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FRAME_BITS-1:0] din,
  output logic [FRAME_BITS-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [FRAME_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [FRAME_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  push_ok, pop_ok;

  assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_q];

  // A push into a full FIFO is legal only alongside a pop; it reuses the slot being freed.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with sticky framing/overrun flags.
// Define UART_RX_FIFO_EN for a 4-entry receive FIFO; otherwise a single holding register.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [FRAME_BITS-1:0] rx_value,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  input  logic                  clear_errors,
  output logic                  framing_error,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BCNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(FRAME_BITS - 1);

  logic                  sync1_q, sync2_q, rx_prev_q;
  logic                  rx_s;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  framing_q, framing_d;
  logic                  overrun_q, overrun_d;
  logic                  store, frame_err_set, overrun_set;

  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bcnt_d        = bcnt_q;
    shift_d       = shift_q;
    store         = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
          bcnt_d  = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[FRAME_BITS-1:1]};
          bcnt_d  = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_LAST) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            store   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_d       = ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FRAME_BITS-1:0] fifo_dout;

  always_comb begin
    fifo_pop    = rx_ack & ~fifo_empty;
    fifo_push   = store & (~fifo_full | fifo_pop);
    overrun_set = store & fifo_full & ~fifo_pop;
  end

  uart_rx_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (shift_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_value = fifo_dout;
  assign rx_valid = ~fifo_empty;
`else
  logic [FRAME_BITS-1:0] hold_q, hold_d;
  logic                  valid_q, valid_d;
  logic                  ack_ok, accept;

  // A same-cycle ack frees the register, so the incoming byte replaces it.
  always_comb begin
    ack_ok      = rx_ack & valid_q;
    accept      = store & (~valid_q | ack_ok);
    overrun_set = store & valid_q & ~ack_ok;
    hold_d      = hold_q;
    valid_d     = valid_q;
    if (accept) begin
      hold_d  = shift_q;
      valid_d = 1'b1;
    end else if (ack_ok) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end

  assign rx_value = hold_q;
  assign rx_valid = valid_q;
`endif

  always_comb begin
    framing_d = frame_err_set | (framing_q & ~clear_errors);
    overrun_d = overrun_set | (overrun_q & ~clear_errors);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      framing_q <= framing_d;
      overrun_q <= overrun_d;
    end
  end

  assign framing_error = framing_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=8; honours UART_RX_FIFO_EN.
module tb_uart_rx;

  localparam int CPB = 8;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int FRAME_CYC = CPB * 10 + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] rx_value;
  logic       rx_valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;
  int         lat = 79;
  logic       rise_busy_before, rise_busy_after;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .rx_value      (rx_value),
    .rx_valid      (rx_valid),
    .rx_ack        (rx_ack),
    .clear_errors  (clear_errors),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; optionally pulses rx_ack on cycle ack_cyc; updates the scoreboard.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int ack_cyc,
                            output int rise);
    logic [9:0] bits;
    logic       pv, pb;
    int         idx;
    bits = {stop_lvl, b, 1'b0};
    rise = -1;
    for (int c = 0; c < FRAME_CYC; c++) begin
      idx    = (c / CPB > 9) ? 9 : c / CPB;
      rx     = bits[idx];
      rx_ack = (c == ack_cyc);
      if (c == ack_cyc) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ack_head: model queue empty at ack, rx_valid=%0b", rx_valid);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_valid !== 1'b1 || rx_value !== e) begin
            errors++;
            $display("FAIL ack_head: got valid=%0b value=%02h, expected valid=1 value=%02h",
                     rx_valid, rx_value, e);
          end
        end
      end
      pv = rx_valid;
      pb = busy;
      @(posedge clk);
      #1;
      if (rise < 0 && rx_valid === 1'b1 && pv === 1'b0) begin
        rise             = c + 1;
        rise_busy_before = pb;
        rise_busy_after  = busy;
      end
    end
    rx_ack = 1'b0;
    if (stop_lvl) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    int wait_cyc;
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      wait_cyc = 0;
      while (rx_valid !== 1'b1 && wait_cyc < 200) begin
        tick(1);
        wait_cyc++;
      end
      e = exp_q.pop_front();
      checks++;
      if (rx_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_timeout: rx_valid never rose, expected byte %02h", name, e);
        exp_q.delete();
      end else begin
        if (rx_value !== e) begin
          errors++;
          $display("FAIL %s_data: got %02h, expected %02h", name, rx_value, e);
        end
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
      end
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_empty: rx_valid=%0b, expected 0", name, rx_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    checks++;
    if ({rx_value, rx_valid, framing_error, overrun, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset: value=%02h valid=%0b fe=%0b ovr=%0b busy=%0b, expected all 0",
               rx_value, rx_valid, framing_error, overrun, busy);
    end
    tick(4);
  endtask

  task automatic test_basic;
    int rise;
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    send_frame(8'hA5, 1'b1, -1, rise);
    checks++;
    if (rise < 74 || rise > 84) begin
      errors++;
      $display("FAIL basic_latency: rx_valid rose after edge %0d, expected 74..84", rise);
    end else begin
      lat = rise;
    end
    checks++;
    if (rise_busy_before !== 1'b1 || rise_busy_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_stop_edge: busy before/after=%0b/%0b, expected 1/0",
               rise_busy_before, rise_busy_after);
    end
    drain("basic");
  endtask

  task automatic test_glitch;
    logic saw_busy;
    saw_busy = 1'b0;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start: busy never rose, expected START entry");
    end
    checks++;
    if ({busy, rx_valid, framing_error, overrun} !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_reject: busy=%0b valid=%0b fe=%0b ovr=%0b, expected 0000",
               busy, rx_valid, framing_error, overrun);
    end
  endtask

  task automatic test_framing;
    int rise;
    send_frame(8'h3C, 1'b0, -1, rise);
    tick(10);
    checks++;
    if (framing_error !== 1'b1 || rx_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL framing_set: fe=%0b valid=%0b busy=%0b, expected 1/0/1",
               framing_error, rx_valid, busy);
    end
    rx = 1'b1;
    tick(5);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL framing_wait_idle: busy=%0b, expected 0", busy);
    end
    clear_errors = 1'b1;
    tick(1);
    clear_errors = 1'b0;
    checks++;
    if (framing_error !== 1'b0) begin
      errors++;
      $display("FAIL framing_clear: fe=%0b, expected 0", framing_error);
    end
  endtask

  task automatic test_overrun;
    int rise;
    logic [7:0] b;
    for (int i = 0; i <= DEPTH; i++) begin
      b = (DEPTH == 1) ? 8'(17 * (i + 1)) : 8'(i + 1);
      send_frame(b, 1'b1, -1, rise);
    end
    checks++;
    if (overrun !== exp_ovr) begin
      errors++;
      $display("FAIL overrun_set: ovr=%0b, expected %0b", overrun, exp_ovr);
    end
    drain("overrun");
    clear_errors = 1'b1;
    tick(1);
    clear_errors = 1'b0;
    exp_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: ovr=%0b, expected 0", overrun);
    end
  endtask

  task automatic test_back_to_back_ack;
    int rise;
    for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h40 + i), 1'b1, -1, rise);
    send_frame(8'h77, 1'b1, lat - 1, rise);
    checks++;
    if (overrun !== exp_ovr || overrun !== 1'b0) begin
      errors++;
      $display("FAIL collision_overrun: ovr=%0b, expected 0", overrun);
    end
    drain("collision");
  endtask

  task automatic test_reset_midframe;
    int rise;
    send_frame(8'h99, 1'b1, -1, rise);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0;
    checks++;
    if ({rx_value, rx_valid, framing_error, overrun, busy} !== 12'h000) begin
      errors++;
      $display("FAIL midreset_state: value=%02h valid=%0b fe=%0b ovr=%0b busy=%0b, expected all 0",
               rx_value, rx_valid, framing_error, overrun, busy);
    end
    tick(6 * CPB);
    checks++;
    if (rx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abandon: valid=%0b busy=%0b, expected 0/0", rx_valid, busy);
    end
    send_frame(8'h5A, 1'b1, -1, rise);
    drain("midreset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back_ack();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clk cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have port rx, input, 1, asynchronous serial line; idle high; 8N1 frames, LSB first.
REQ-005 SHALL have port rx_value, output, 8, oldest unread received byte.
REQ-006 SHALL have port rx_valid, output, 1, high while at least one unread byte is held.
REQ-007 SHALL have port rx_ack, input, 1, one-cycle pulse that consumes the current rx_value.
REQ-008 SHALL have port clear_errors, input, 1, one-cycle pulse that clears the sticky error flags.
REQ-009 SHALL have port framing_error, output, 1, sticky flag: a stop bit was sampled low.
REQ-010 SHALL have port overrun, output, 1, sticky flag: a byte completed with no storage free.
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; only the synchronized signal feeds the FSM.
REQ-013 SHALL implement the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-014 IDLE: a synchronized high-to-low transition SHALL enter START and clear the bit counter.
REQ-015 START: after CLKS_PER_BIT/2 cycles (integer division), the FSM SHALL sample rx; low -> DATA; high -> IDLE (glitch rejected, no flags set).
REQ-016 DATA: the FSM SHALL sample every CLKS_PER_BIT cycles, shift each sample into bit 7 of the shift register (right-shift), and move to STOP after the 8th sample.
REQ-017 STOP: after CLKS_PER_BIT cycles, the FSM SHALL sample rx.
- High: store the byte and go to IDLE.
- Low: set framing_error, discard the byte, go to WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL return to IDLE on the first cycle the synchronized rx is high.
REQ-019 On a stored byte, rx_valid and the new rx_value SHALL be visible on the cycle after the stop-bit sample.
REQ-020 An rx_ack while rx_valid=1 SHALL consume one byte; an rx_ack while rx_valid=0 SHALL be ignored.
REQ-021 If a store and an rx_ack occur on the same cycle with storage full, the new byte SHALL be accepted and overrun SHALL NOT be set.
REQ-022 If a store occurs with storage full and no rx_ack, the new byte SHALL be dropped, stored data SHALL be unchanged, and overrun SHALL be set.
REQ-023 clear_errors SHALL clear both sticky flags; an error event on the same cycle SHALL win (flag stays set).
REQ-024 Counters SHALL be wide enough for CLKS_PER_BIT-1 and SHALL NOT wrap mid-bit.

Reset
REQ-025 When rst_n=0 at a clk edge, the block SHALL enter IDLE and load synchronizer flops to 1.
REQ-026 Reset values SHALL be: rx_value=0, rx_valid=0, framing_error=0, overrun=0, busy=0; storage empty.
REQ-027 A reset mid-frame SHALL abandon the frame; the remaining bits SHALL NOT produce a byte unless a new falling edge is seen in IDLE.

Configuration
REQ-028 Macro UART_RX_FIFO_EN defined: storage SHALL be a 4-entry FIFO; rx_value shows the head; full = 4 entries.
REQ-029 Macro UART_RX_FIFO_EN undefined: storage SHALL be a single holding register; full = rx_valid.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding, the default CLKS_PER_BIT and the frame length constant (8 data bits).
REQ-031 The FIFO SHALL be a sub-module uart_rx_fifo (4x8, push/pop/full/empty), instantiated only under UART_RX_FIFO_EN.

Verification (CLKS_PER_BIT=8)
REQ-032 Frame 0xA5 with a valid stop bit -> rx_valid=1 and rx_value=0xA5 one cycle after the stop sample; rx_ack -> rx_valid=0.
REQ-033 rx low for 2 cycles, then high -> START returns to IDLE; no rx_valid; no flags set.
REQ-034 Frame 0x3C with stop bit low -> framing_error=1, rx_valid=0; rx held low stays in WAIT_IDLE; clear_errors -> framing_error=0.
REQ-035 Bytes without rx_ack:
- No FIFO: 0x11 then 0x22 -> rx_value=0x11, overrun=1.
- FIFO: 0x01..0x05 -> 0x01..0x04 read back in order, overrun=1.
REQ-036 Storage full, and rx_ack on the same cycle as the next store (0x77) -> overrun=0, 0x77 readable.
REQ-037 rst_n pulsed during DATA of frame 0xFF -> all outputs at reset values; the next frame 0x5A is received correctly.
